// File: rtl/bootdata_responder.sv
// -----------------------------------------------------------------------------
// bootdata_responder
//
// Host-side responder for the boot-ROM word handshake. Bytes of the ROM image
// are drained from a byte FIFO (registered-output: data valid the cycle after
// the read strobe), packed four at a time into a 32-bit word, and handed to the
// ROM loader one word per request with a single-cycle acknowledge. Once
// BOOT_WORDS words have been delivered the block parks in a terminal state and
// raises done.
//
// Ports
//   clk                 in   single clock, all logic on posedge
//   reset               in   synchronous, active-high
//   fifo_empty          in   byte FIFO empty flag
//   fifo_rd             out  FIFO read strobe, one byte per high cycle
//   fifo_data[7:0]      in   FIFO output, valid the cycle after fifo_rd
//   host_bootdata_req   in   level request from the ROM loader
//   host_bootdata_ack   out  one-cycle pulse, host_bootdata valid that cycle
//   host_bootdata[31:0] out  delivered word, held until the next ack
//   words_sent          out  number of words acknowledged since reset
//   done                out  high once words_sent reaches BOOT_WORDS
// -----------------------------------------------------------------------------
module bootdata_responder #(
    parameter int BOOT_WORDS = 8192,
    parameter int COUNT_W    = 14,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fifo_empty,
    output logic               fifo_rd,
    input  logic [7:0]         fifo_data,
    input  logic               host_bootdata_req,
    output logic               host_bootdata_ack,
    output logic [31:0]        host_bootdata,
    output logic [COUNT_W-1:0] words_sent,
    output logic               done
);

    localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(BOOT_WORDS);

    typedef enum logic [2:0] {
        S_FILL,
        S_READY,
        S_ACK,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [2:0]         byte_idx_reg, byte_idx_next;
    logic               rd_pending_reg, rd_pending_next;
    logic [31:0]        bootdata_reg, bootdata_next;
    logic [COUNT_W-1:0] words_reg, words_next;
    logic [3:0]         lane_we;
    logic [31:0]        packed_word;
    logic               rd_en;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_FILL;
            byte_idx_reg   <= 3'd0;
            rd_pending_reg <= 1'b0;
            bootdata_reg   <= 32'd0;
            words_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            byte_idx_reg   <= byte_idx_next;
            rd_pending_reg <= rd_pending_next;
            bootdata_reg   <= bootdata_next;
            words_reg      <= words_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and control
    // -------------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        byte_idx_next   = byte_idx_reg;
        rd_pending_next = 1'b0;
        bootdata_next   = bootdata_reg;
        words_next      = words_reg;
        lane_we         = 4'b0000;
        rd_en           = 1'b0;

        case (state_reg)
            S_FILL: begin
                // A read is only issued when no byte is in flight, which
                // leaves a dead cycle between reads and guarantees the
                // captured byte lands in the lane the index points at.
                rd_en           = !fifo_empty && !rd_pending_reg && (byte_idx_reg < 3'd4);
                rd_pending_next = rd_en;
                // The in-flight byte is captured even if the FIFO has just
                // gone empty; its data was committed by the earlier strobe.
                if (rd_pending_reg) begin
                    lane_we[byte_idx_reg[1:0]] = 1'b1;
                    byte_idx_next              = byte_idx_reg + 3'd1;
                    if (byte_idx_reg == 3'd3) begin
                        state_next = S_READY;
                    end
                end
            end

            S_READY: begin
                // Request is level-sampled here only; anything seen while
                // filling is deliberately not remembered.
                if (host_bootdata_req) begin
                    bootdata_next = packed_word;
                    state_next    = S_ACK;
                end
            end

            S_ACK: begin
                words_next = words_reg + 1'b1;
                state_next = S_GAP;
            end

            S_GAP: begin
                // One dead cycle so a requester holding req high cannot get
                // two acks for the same word.
                byte_idx_next = 3'd0;
                state_next    = (words_reg == LAST_COUNT) ? S_DONE : S_FILL;
            end

            S_DONE: begin
                state_next = S_DONE;
            end

            default: begin
                state_next = S_FILL;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Byte lanes and word packing
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    lane_reg <= 8'd0;
                end else if (lane_we[gi]) begin
                    lane_reg <= fifo_data;
                end
            end

            // Lane gi holds the gi-th byte read for the current word.
            if (BIG_ENDIAN) begin : g_be
                assign packed_word[31-8*gi -: 8] = lane_reg;
            end else begin : g_le
                assign packed_word[8*gi +: 8] = lane_reg;
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Gated by reset so no FIFO byte is consumed while the block is held.
    assign fifo_rd           = rd_en && !reset;
    assign host_bootdata_ack = (state_reg == S_ACK);
    assign host_bootdata     = bootdata_reg;
    assign words_sent        = words_reg;
    assign done              = (state_reg == S_DONE);

endmodule
